uart_mike_rx: RTL and testbench

//   Serial receive datapath of the UART: synchronises rx_in and detects a start bit.

---
 rtl/uart_mike_rx.sv | 155 +++++++++++++++
 tb/tb_uart_mike_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mike_rx.sv
// ---------------------------------------------------------------------------
// uart_mike_rx
//   Serial receive datapath of the UART. The line is brought into the clock
//   domain through a 2-flop synchroniser. A falling edge starts a frame. The
//   start bit is confirmed at mid-bit. Data bits are taken LSB first at
//   mid-bit, and the stop bit is checked. A good byte is held behind a
//   sticky flag until software clears it.
//
// Ports
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   rx_in         in   serial line, idle high, asynchronous to clk
//   rx_flag_clr   in   clears rx_flag and rx_overrun
//   rx_start      out  1-cycle pulse: start bit confirmed at mid-bit
//   rx_done       out  1-cycle pulse: frame ended (good or framing error)
//   rx_data       out  last good byte, held stable while rx_flag=1
//   rx_flag       out  good byte available, sticky until rx_flag_clr
//   rx_frame_err  out  valid with rx_done: stop bit sampled 0
//   rx_overrun    out  sticky: good frame ended while rx_flag already set
// ---------------------------------------------------------------------------
module uart_mike_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  rx_in,
  input  logic                  rx_flag_clr,
  output logic                  rx_start,
  output logic                  rx_done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_flag,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                  r_sync1;
  logic                  r_sync2;
  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_armed;

  logic       w_rx_s;
  logic [1:0] w_state_nxt;
  logic       w_mid_start;
  logic       w_bit_tick;
  logic       w_stop_tick;
  logic       w_good;
  logic       w_load;

  assign w_rx_s      = r_sync2;
  assign w_mid_start = (r_state == S_START) && (r_bit_cnt == CNT_HALF);
  assign w_bit_tick  = (r_bit_cnt == CNT_LAST);
  assign w_stop_tick = (r_state == S_STOP) && w_bit_tick;
  assign w_good      = w_stop_tick && w_rx_s;
  // Set wins over a coincident clear.
  assign w_load      = w_good && (!rx_flag || rx_flag_clr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // r_armed blocks a held-low line (break) from retriggering.
      S_IDLE:  if (!w_rx_s && r_armed) w_state_nxt = S_START;
      S_START: if (w_mid_start) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_tick && (r_bit_idx == IDX_LAST)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_tick) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Synchroniser, resets to line-idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Frame sequencing: state, bit timing, deserialiser.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_armed   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;

      if ((w_state_nxt != r_state) || (r_state == S_IDLE) || w_bit_tick)
        r_bit_cnt <= '0;
      else
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);

      if (w_mid_start)
        r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_bit_tick)
        r_bit_idx <= r_bit_idx + IDX_W'(1);

      if ((r_state == S_DATA) && w_bit_tick)
        r_shreg <= {w_rx_s, r_shreg[DATA_WIDTH-1:1]};

      // Re-arm only once the line has been seen high again.
      if (w_rx_s)
        r_armed <= 1'b1;
      else if (w_stop_tick)
        r_armed <= 1'b0;
    end
  end

  // Output pulses and the software-visible holding register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_start     <= 1'b0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_data      <= '0;
      rx_flag      <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_start     <= w_mid_start && !w_rx_s;
      rx_done      <= w_stop_tick;
      rx_frame_err <= w_stop_tick && !w_rx_s;

      if (w_load) begin
        rx_data <= r_shreg;
        rx_flag <= 1'b1;
        if (rx_flag_clr) rx_overrun <= 1'b0;
      end else if (w_good) begin
        rx_overrun <= 1'b1;
      end else if (rx_flag_clr) begin
        rx_flag    <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_mike_rx.sv
module tb_uart_mike_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          rx_in;
  logic          rx_flag_clr;
  logic          rx_start;
  logic          rx_done;
  logic [DW-1:0] rx_data;
  logic          rx_flag;
  logic          rx_frame_err;
  logic          rx_overrun;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_both = 0;
  int done_cyc = 0;
  logic [DW-1:0] last_data = '0, prev_data = '0;

  uart_mike_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_in        (rx_in),
    .rx_flag_clr  (rx_flag_clr),
    .rx_start     (rx_start),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .rx_flag      (rx_flag),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_start) n_start <= n_start + 1;
    if (rx_start && rx_done) n_both <= n_both + 1;
    if (rx_done) begin
      n_done    <= n_done + 1;
      done_cyc  <= cyc;
      prev_data <= last_data;
      last_data <= rx_data;
      if (rx_frame_err) n_err <= n_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive cycles [0, ncyc) of a frame; clr pulses in cycle clr_at (-1 = never).
  task automatic send_part(input logic [DW-1:0] d, input logic stopb, input int ncyc,
                           input int clr_at);
    logic [DW+1:0] bits;
    bits = {stopb, d, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      rx_in       = bits[i / CPB];
      rx_flag_clr = (i == clr_at);
      tick(1);
    end
    rx_flag_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stopb, input int clr_at);
    send_part(d, stopb, (DW + 2) * CPB, clr_at);
    rx_in = 1'b1;
  endtask

  task automatic pulse_clr();
    rx_flag_clr = 1'b1;
    tick(1);
    rx_flag_clr = 1'b0;
    tick(1);
  endtask

  int s0, d0, e0, c0;

  initial begin
    n_rst = 1'b0; rx_in = 1'b1; rx_flag_clr = 1'b0;
    tick(3);
    chk("rst_start", rx_start, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flag", rx_flag, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    n_rst = 1'b1;
    tick(20);

    // 1: clean 0xA5
    s0 = n_start; d0 = n_done; e0 = n_err; c0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    tick(20);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_dones", n_done - d0, 1);
    chk("t1_err", n_err - e0, 0);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_flag", rx_flag, 1);
    chk("t1_latency_155", done_cyc - c0, 155);
    pulse_clr();
    chk("t1_clr_flag", rx_flag, 0);

    // 2: 4-cycle glitch
    s0 = n_start; d0 = n_done;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(40);
    chk("t2_starts", n_start - s0, 0);
    chk("t2_dones", n_done - d0, 0);

    // 3: framing error
    d0 = n_done; e0 = n_err;
    send_frame(8'h3C, 1'b0, -1);
    tick(40);
    chk("t3_dones", n_done - d0, 1);
    chk("t3_err", n_err - e0, 1);
    chk("t3_flag", rx_flag, 0);
    chk("t3_data", rx_data, 8'hA5);

    // 4: overrun
    send_frame(8'h11, 1'b1, -1);
    tick(20);
    send_frame(8'h22, 1'b1, -1);
    tick(20);
    chk("t4_data", rx_data, 8'h11);
    chk("t4_ovr", rx_overrun, 1);
    chk("t4_flag", rx_flag, 1);
    pulse_clr();
    chk("t4_clr_flag", rx_flag, 0);
    chk("t4_clr_ovr", rx_overrun, 0);

    // 5: back-to-back, clear coincident with second rx_done
    d0 = n_done; e0 = n_err;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 154);
    tick(20);
    chk("t5_dones", n_done - d0, 2);
    chk("t5_err", n_err - e0, 0);
    chk("t5_first", prev_data, 8'h00);
    chk("t5_second", last_data, 8'hFF);
    chk("t5_data", rx_data, 8'hFF);
    chk("t5_flag", rx_flag, 1);
    chk("t5_ovr", rx_overrun, 0);
    pulse_clr();

    // 6: reset mid-frame after bit 3 of 0x5A
    d0 = n_done;
    send_part(8'h5A, 1'b1, 5 * CPB, -1);
    n_rst = 1'b0;
    rx_in = 1'b1;
    tick(1);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_flag", rx_flag, 0);
    chk("t6_rst_done", rx_done, 0);
    tick(2);
    n_rst = 1'b1;
    tick(200);
    chk("t6_no_done", n_done - d0, 0);
    send_frame(8'h81, 1'b1, -1);
    tick(20);
    chk("t6_data", rx_data, 8'h81);
    chk("t6_flag", rx_flag, 1);
    chk("t6_dones", n_done - d0, 1);
    pulse_clr();

    // Break: line held low for many bit times
    d0 = n_done; e0 = n_err; s0 = n_start;
    rx_in = 1'b0;
    tick(40 * CPB);
    rx_in = 1'b1;
    tick(40);
    chk("brk_dones", n_done - d0, 1);
    chk("brk_err", n_err - e0, 1);
    chk("brk_starts", n_start - s0, 1);
    send_frame(8'h42, 1'b1, -1);
    tick(20);
    chk("brk_after_data", rx_data, 8'h42);

    chk("start_done_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
